// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from a byte fifo and re-emits the payload as a
// valid/ready byte stream with sop/eop markers, through a 2-entry skid buffer.
module fifo_pkt_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  zero_cnt
);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_rem;
  logic              r_first;
  logic [1:0]        r_bcnt;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_sop0, r_sop1, r_eop0, r_eop1;
  logic [CNT_W-1:0]  r_pkt_cnt, r_zero_cnt;

  logic w_pop, w_push, w_hdr, w_new_eop;

  assign fifo_r    = reset_n & ~fifo_empty & (r_bcnt < 2'd2);
  assign w_pop     = (r_bcnt != 2'd0) & m_ready;
  assign w_push    = fifo_r & (r_state == PAYLOAD);
  assign w_hdr     = fifo_r & (r_state == IDLE);
  assign w_new_eop = (r_rem == DATA_W'(1));

  assign m_valid  = (r_bcnt != 2'd0);
  assign m_data   = r_data0;
  assign m_sop    = r_sop0;
  assign m_eop    = r_eop0;
  assign busy     = (r_state == PAYLOAD) | (r_bcnt != 2'd0);
  assign pkt_cnt  = r_pkt_cnt;
  assign zero_cnt = r_zero_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr && (fifo_data != '0)) begin
            r_rem   <= fifo_data;
            r_first <= 1'b1;
            r_state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_push) begin
            r_rem   <= r_rem - DATA_W'(1);
            r_first <= 1'b0;
            if (w_new_eop) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Slot 0 is the head; a push lands in the first free slot, and with a
  // simultaneous pop it lands where the head will be after the shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt  <= 2'd0;
      r_data0 <= '0;
      r_sop0  <= 1'b0;
      r_eop0  <= 1'b0;
      r_data1 <= '0;
      r_sop1  <= 1'b0;
      r_eop1  <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_bcnt == 2'd0) begin
            r_data0 <= fifo_data;
            r_sop0  <= r_first;
            r_eop0  <= w_new_eop;
          end else begin
            r_data1 <= fifo_data;
            r_sop1  <= r_first;
            r_eop1  <= w_new_eop;
          end
          r_bcnt <= r_bcnt + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_sop0  <= r_sop1;
          r_eop0  <= r_eop1;
          r_bcnt  <= r_bcnt - 2'd1;
        end
        2'b11: begin
          if (r_bcnt == 2'd1) begin
            r_data0 <= fifo_data;
            r_sop0  <= r_first;
            r_eop0  <= w_new_eop;
          end else begin
            r_data0 <= r_data1;
            r_sop0  <= r_sop1;
            r_eop0  <= r_eop1;
            r_data1 <= fifo_data;
            r_sop1  <= r_first;
            r_eop1  <= w_new_eop;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt  <= '0;
      r_zero_cnt <= '0;
    end else begin
      if (w_pop && r_eop0) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      if (w_hdr && (fifo_data == '0)) r_zero_cnt <= r_zero_cnt + CNT_W'(1);
    end
  end

endmodule
